// File: rtl/mul_wb_pkg.sv
// Shared types, saturation constants and the result-select function for the multiplier writeback stage.
// Optional build macro: MUL_WB_SATURATE_EN (saturate a low-half result that overflowed).
package mul_wb_pkg;

  localparam int MUL_DATA_W = 64;
  localparam int MUL_TAG_W  = 5;

  localparam logic [MUL_DATA_W-1:0] SAT_MAX = {1'b0, {(MUL_DATA_W-1){1'b1}}};
  localparam logic [MUL_DATA_W-1:0] SAT_MIN = {1'b1, {(MUL_DATA_W-1){1'b0}}};

  typedef struct packed {
    logic [MUL_DATA_W-1:0] data;
    logic [MUL_TAG_W-1:0]  rd;
    logic                  zero;
    logic                  neg;
    logic                  ovf;
  } mul_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  // Builds a complete FIFO entry from the raw multiplier outputs.
  function automatic mul_entry_t mul_select(
    input logic [2*MUL_DATA_W-1:0] prod,
    input logic                    ovf_in,
    input logic                    sel_hi,
    input logic [MUL_TAG_W-1:0]    rd
  );
    mul_entry_t            e;
    logic [MUL_DATA_W-1:0] hi_half;
    logic [MUL_DATA_W-1:0] lo_half;
`ifdef MUL_WB_SATURATE_EN
    logic                  true_sign;
`endif
    e       = '0;
    hi_half = prod[2*MUL_DATA_W-1:MUL_DATA_W];
    lo_half = prod[MUL_DATA_W-1:0];
    e.rd    = rd;
    if (sel_hi) begin
      e.data = hi_half;
      e.ovf  = ovf_in;
    end else begin
      e.data = lo_half;
      // Low half is only exact when the high half is a pure sign extension of it.
      e.ovf  = ovf_in | (hi_half != {MUL_DATA_W{lo_half[MUL_DATA_W-1]}});
`ifdef MUL_WB_SATURATE_EN
      if (e.ovf) begin
        true_sign = prod[2*MUL_DATA_W-1] ^ ovf_in;
        e.data    = true_sign ? SAT_MIN : SAT_MAX;
      end
`endif
    end
    e.zero = (e.data == '0);
    e.neg  = e.data[MUL_DATA_W-1];
    return e;
  endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// Generic DEPTH-entry FIFO with valid/ready on both sides and an occupancy FSM.
// Ready on the push side depends only on registered state, never on the pop side.
//
// state        | meaning
// OCC_EMPTY    | count == 0, nothing to present
// OCC_PARTIAL  | 0 < count < DEPTH, can push and pop
// OCC_FULL     | count == DEPTH, push side stalled
module mul_wb_fifo
  import mul_wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = mul_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push_valid,
  output logic                     o_push_ready,
  input  T                         i_push_data,
  output logic                     o_pop_valid,
  input  logic                     i_pop_ready,
  output T                         o_pop_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  occ_state_t       r_state;
  occ_state_t       w_state_nxt;
  logic             w_push;
  logic             w_pop;

  assign o_push_ready = (r_state != OCC_FULL);
  assign o_pop_valid  = (r_state != OCC_EMPTY);
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = o_pop_valid & i_pop_ready;
  assign o_count      = r_count;
  assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : '0;

  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
    if (w_count_nxt == '0) begin
      w_state_nxt = OCC_EMPTY;
    end else if (w_count_nxt == CNT_W'(DEPTH)) begin
      w_state_nxt = OCC_FULL;
    end else begin
      w_state_nxt = OCC_PARTIAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OCC_EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/mul_wb_stage.sv
// Writeback stage after the 64x64 signed multiplier: half select, flags, dest tag, small FIFO.
// Optional build macro: MUL_WB_SATURATE_EN (saturate overflowed low-half results).
module mul_wb_stage
  import mul_wb_pkg::*;
#(
  parameter int DATA_W = MUL_DATA_W,
  parameter int TAG_W  = MUL_TAG_W,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [2*DATA_W-1:0]     i_prod,
  input  logic                    i_ovf,
  input  logic                    i_sel_hi,
  input  logic [TAG_W-1:0]        i_rd,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_W-1:0]       o_data,
  output logic [TAG_W-1:0]        o_rd,
  output logic                    o_zero,
  output logic                    o_neg,
  output logic                    o_ovf,
  output logic [$clog2(DEPTH):0]  o_count
);

  mul_entry_t w_push_entry;
  mul_entry_t w_head_entry;

  // Flags are resolved before storage so the FIFO head drives writeback with no extra logic.
  assign w_push_entry = mul_select(i_prod, i_ovf, i_sel_hi, i_rd);

  mul_wb_fifo #(
    .DEPTH (DEPTH),
    .T     (mul_entry_t)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (i_valid),
    .o_push_ready (o_ready),
    .i_push_data  (w_push_entry),
    .o_pop_valid  (o_valid),
    .i_pop_ready  (i_ready),
    .o_pop_data   (w_head_entry),
    .o_count      (o_count)
  );

  assign o_data = w_head_entry.data;
  assign o_rd   = w_head_entry.rd;
  assign o_zero = w_head_entry.zero;
  assign o_neg  = w_head_entry.neg;
  assign o_ovf  = w_head_entry.ovf;

endmodule

// File: tb/tb_mul_wb_stage.sv
// Directed self-checking bench for mul_wb_stage (DEPTH=2); expectations follow MUL_WB_SATURATE_EN.
module tb_mul_wb_stage;

  logic           clk;
  logic           rst;
  logic           i_valid;
  logic           o_ready;
  logic [127:0]   i_prod;
  logic           i_ovf;
  logic           i_sel_hi;
  logic [4:0]     i_rd;
  logic           o_valid;
  logic           i_ready;
  logic [63:0]    o_data;
  logic [4:0]     o_rd;
  logic           o_zero;
  logic           o_neg;
  logic           o_ovf;
  logic [1:0]     o_count;

  int errors = 0;
  int checks = 0;

  mul_wb_stage #(.DATA_W(64), .TAG_W(5), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_prod   (i_prod),
    .i_ovf    (i_ovf),
    .i_sel_hi (i_sel_hi),
    .i_rd     (i_rd),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_rd     (o_rd),
    .o_zero   (o_zero),
    .o_neg    (o_neg),
    .o_ovf    (o_ovf),
    .o_count  (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] prod, input logic ovf, input logic hi, input logic [4:0] rd);
    i_valid  = 1'b1;
    i_prod   = prod;
    i_ovf    = ovf;
    i_sel_hi = hi;
    i_rd     = rd;
  endtask

  task automatic idle();
    i_valid  = 1'b0;
    i_prod   = '0;
    i_ovf    = 1'b0;
    i_sel_hi = 1'b0;
    i_rd     = '0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (3) tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    checks++; if (o_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_data); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
  endtask

  task automatic test_reset_midstream();
    i_ready = 1'b0;
    drive(128'd11, 1'b0, 1'b0, 5'd1); tick();
    drive(128'd12, 1'b0, 1'b0, 5'd2); tick();
    idle();
    checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL mid_prefill_count got=%0d exp=2", o_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", o_count); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b exp=0", o_valid); end
    #3 rst = 1'b0;
    tick();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%0b exp=1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid_after got=%0b exp=0", o_valid); end
  endtask

  task automatic test_basic();
    i_ready = 1'b0;
    drive({64'd0, 64'd6}, 1'b0, 1'b0, 5'd3); tick(); idle();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
    checks++; if (o_data !== 64'd6) begin errors++; $display("FAIL basic_data got=%h exp=6", o_data); end
    checks++; if (o_rd !== 5'd3) begin errors++; $display("FAIL basic_rd got=%0d exp=3", o_rd); end
    checks++; if ({o_zero, o_neg, o_ovf} !== 3'b000) begin errors++; $display("FAIL basic_flags got=%b exp=000", {o_zero, o_neg, o_ovf}); end
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL basic_pop_count got=%0d exp=0", o_count); end
  endtask

  task automatic test_overflow();
    logic [63:0] exp_d;
    logic [2:0]  exp_f;
    // Positive overflow: hi=1, low half zero.
`ifdef MUL_WB_SATURATE_EN
    exp_d = 64'h7FFF_FFFF_FFFF_FFFF; exp_f = 3'b001;
`else
    exp_d = 64'h0; exp_f = 3'b101;
`endif
    i_ready = 1'b0;
    drive(128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0, 5'd7); tick(); idle();
    checks++; if (o_data !== exp_d) begin errors++; $display("FAIL ovf_pos_data got=%h exp=%h", o_data, exp_d); end
    checks++; if ({o_zero, o_neg, o_ovf} !== exp_f) begin errors++; $display("FAIL ovf_pos_flags got=%b exp=%b", {o_zero, o_neg, o_ovf}, exp_f); end
    drain();
    // Negative overflow: hi=-2, low half zero.
`ifdef MUL_WB_SATURATE_EN
    exp_d = 64'h8000_0000_0000_0000; exp_f = 3'b011;
`else
    exp_d = 64'h0; exp_f = 3'b101;
`endif
    drive(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0000, 1'b0, 1'b0, 5'd8); tick(); idle();
    checks++; if (o_data !== exp_d) begin errors++; $display("FAIL ovf_neg_data got=%h exp=%h", o_data, exp_d); end
    checks++; if ({o_zero, o_neg, o_ovf} !== exp_f) begin errors++; $display("FAIL ovf_neg_flags got=%b exp=%b", {o_zero, o_neg, o_ovf}, exp_f); end
    drain();
    // Incoming ovf on a high-half select is reported but never saturated.
    drive(128'd5, 1'b1, 1'b1, 5'd9); tick(); idle();
    checks++; if (o_data !== 64'd0) begin errors++; $display("FAIL ovf_hi_data got=%h exp=0", o_data); end
    checks++; if ({o_zero, o_neg, o_ovf} !== 3'b101) begin errors++; $display("FAIL ovf_hi_flags got=%b exp=101", {o_zero, o_neg, o_ovf}); end
    drain();
  endtask

  task automatic test_high_half();
    i_ready = 1'b0;
    drive({128{1'b1}}, 1'b0, 1'b1, 5'd31); tick(); idle();
    checks++; if (o_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL hi_data got=%h exp=ffffffffffffffff", o_data); end
    checks++; if ({o_zero, o_neg, o_ovf} !== 3'b010) begin errors++; $display("FAIL hi_flags got=%b exp=010", {o_zero, o_neg, o_ovf}); end
    checks++; if (o_rd !== 5'd31) begin errors++; $display("FAIL hi_rd got=%0d exp=31", o_rd); end
    drain();
  endtask

  task automatic test_full();
    i_ready = 1'b0;
    drive(128'd10, 1'b0, 1'b0, 5'd1); tick();
    drive(128'd20, 1'b0, 1'b0, 5'd2); tick();
    drive(128'd30, 1'b0, 1'b0, 5'd3); tick(); idle();
    checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL full_count got=%0d exp=2", o_count); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", o_ready); end
    tick();
    checks++; if (o_data !== 64'd10 || o_rd !== 5'd1) begin errors++; $display("FAIL full_stall_head got=%0d/%0d exp=10/1", o_data, o_rd); end
    i_ready = 1'b1; tick();
    checks++; if (o_data !== 64'd20 || o_rd !== 5'd2) begin errors++; $display("FAIL full_second got=%0d/%0d exp=20/2", o_data, o_rd); end
    checks++; if (o_count !== 2'd1) begin errors++; $display("FAIL full_count_after got=%0d exp=1", o_count); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_drained got=%0b exp=0", o_valid); end
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0;
    drive(128'd99, 1'b0, 1'b0, 5'd0); tick();
    i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(128'(100 + k), 1'b0, 1'b0, 5'(k + 1));
      tick();
      checks++;
      if (o_count !== 2'd1 || o_data !== 64'(100 + k) || o_rd !== 5'(k + 1)) begin
        errors++;
        $display("FAIL b2b_%0d got cnt=%0d data=%0d rd=%0d exp cnt=1 data=%0d rd=%0d", k, o_count, o_data, o_rd, 100 + k, k + 1);
      end
    end
    idle(); tick();
    checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL b2b_final_count got=%0d exp=0", o_count); end
    i_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_ready = 1'b0;
    idle();
    #22;
    test_reset();
    rst = 1'b0;
    tick();
    test_reset_midstream();
    test_basic();
    test_overflow();
    test_high_half();
    test_full();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
